// File: rtl/traffic_request_sequencer.sv
// traffic_request_sequencer
// Upstream command source for the intersection controller. It synchronizes and
// debounces the pedestrian, emergency and caution inputs, arbitrates between
// them, and drives the controller's ld/data/en command interface.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_ni         asynchronous active-low reset
//   auto_en_i      normal cycling permitted (sampled only in IDLE)
//   ped_ns_btn_i   async pedestrian button, north-south crossing
//   ped_ew_btn_i   async pedestrian button, east-west crossing
//   emerg_req_i    async level, emergency preemption
//   caution_req_i  async level, all-yellow caution mode
//   ld_o           load strobe to the controller
//   data_o[3:0]    state code, valid whenever ld_o=1, held otherwise
//   en_o           run enable to the controller, never high with ld_o
//   busy_o         FSM is not in IDLE
//   ped_ns_ack_o   one-cycle pulse when a north-south request is served
//   ped_ew_ack_o   one-cycle pulse when an east-west request is served
//
// State    | meaning
// IDLE     | en follows auto_en, waiting for a request to select
// LOAD     | ld strobe with the latched request code
// APPLY    | en pulse so the controller acts on the loaded code
// HOLD     | ld held with the latched code until the exit condition
// RESUME   | ld strobe with the green code to resume normal cycling
module traffic_request_sequencer #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned PED_CYCLES = 1000,
    parameter int unsigned EMERG_MIN  = 500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       auto_en_i,
    input  logic       ped_ns_btn_i,
    input  logic       ped_ew_btn_i,
    input  logic       emerg_req_i,
    input  logic       caution_req_i,
    output logic       ld_o,
    output logic [3:0] data_o,
    output logic       en_o,
    output logic       busy_o,
    output logic       ped_ns_ack_o,
    output logic       ped_ew_ack_o
);

    localparam logic [3:0]  CODE_ALL_RED    = 4'b0110;
    localparam logic [3:0]  CODE_ALL_YELLOW = 4'b1000;
    localparam logic [3:0]  CODE_NS_GREEN   = 4'b0000;
    localparam logic [3:0]  CODE_EW_GREEN   = 4'b0010;
    localparam logic [15:0] DEB_LAST   = 16'(DEB_CYCLES - 1);
    localparam logic [15:0] PED_LAST   = 16'(PED_CYCLES - 1);
    localparam logic [15:0] EMERG_LAST = 16'(EMERG_MIN - 1);

    // Input lanes: 0 ped_ns, 1 ped_ew, 2 emerg, 3 caution
    localparam int L_NS = 0, L_EW = 1, L_EMERG = 2, L_CAUT = 3;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_APPLY, S_HOLD, S_RESUME} state_t;
    typedef enum logic [1:0] {RQ_EMERG, RQ_CAUTION, RQ_PED_NS, RQ_PED_EW} req_t;

    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_q, deb_d, deb_prev_q;
    logic [3:0][15:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]       pend_q, pend_d, pend_clr, ped_rise;

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [3:0]  code_q, code_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        ld_q, ld_d, en_q, en_d, busy_q, busy_d;
    logic [3:0]  data_q, data_d;
    logic        ns_ack_q, ns_ack_d, ew_ack_q, ew_ack_d;

    assign raw = {caution_req_i, emerg_req_i, ped_ew_btn_i, ped_ns_btn_i};

    // Debounce: count disagreeing cycles, flip once DEB_CYCLES in a row are seen
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else                          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
            end
        end
    end

    // Only a fresh press marks a request; holding or re-pressing while pending is absorbed
    assign ped_rise = deb_q[1:0] & ~deb_prev_q[1:0];
    assign pend_d   = (pend_q & ~pend_clr) | ped_rise;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        code_d     = code_q;
        hold_cnt_d = hold_cnt_q;
        pend_clr   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (auto_en_i) begin
                    if (deb_q[L_EMERG]) begin
                        req_d = RQ_EMERG;   code_d = CODE_ALL_RED;    state_d = S_LOAD;
                    end else if (deb_q[L_CAUT]) begin
                        req_d = RQ_CAUTION; code_d = CODE_ALL_YELLOW; state_d = S_LOAD;
                    end else if (pend_q[L_NS]) begin
                        req_d = RQ_PED_NS;  code_d = CODE_ALL_RED;    state_d = S_LOAD;
                    end else if (pend_q[L_EW]) begin
                        req_d = RQ_PED_EW;  code_d = CODE_ALL_RED;    state_d = S_LOAD;
                    end
                end
            end
            S_LOAD:  state_d = S_APPLY;
            S_APPLY: begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
            end
            S_HOLD: begin
                if (hold_cnt_q != 16'hFFFF) hold_cnt_d = hold_cnt_q + 16'd1;
                // Emergency restarts the sequence; a preempted pedestrian stays pending
                if (req_q != RQ_EMERG && deb_q[L_EMERG]) begin
                    req_d   = RQ_EMERG;
                    code_d  = CODE_ALL_RED;
                    state_d = S_LOAD;
                end else begin
                    unique case (req_q)
                        RQ_PED_NS, RQ_PED_EW:
                            if (hold_cnt_q == PED_LAST) state_d = S_RESUME;
                        RQ_EMERG:
                            if (!deb_q[L_EMERG] && hold_cnt_q >= EMERG_LAST) state_d = S_RESUME;
                        RQ_CAUTION:
                            if (!deb_q[L_CAUT]) state_d = S_RESUME;
                        default: state_d = S_RESUME;
                    endcase
                    if (state_d == S_RESUME) begin
                        pend_clr[L_NS] = (req_q == RQ_PED_NS);
                        pend_clr[L_EW] = (req_q == RQ_PED_EW);
                    end
                end
            end
            S_RESUME: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are registered and decoded from the state being entered
    always_comb begin
        ld_d     = (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RESUME);
        en_d     = (state_d == S_APPLY) || ((state_d == S_IDLE) && auto_en_i);
        busy_d   = (state_d != S_IDLE);
        ns_ack_d = (state_d == S_RESUME) && (req_q == RQ_PED_NS);
        ew_ack_d = (state_d == S_RESUME) && (req_q == RQ_PED_EW);
        data_d   = data_q;
        if (state_d == S_LOAD || state_d == S_HOLD) data_d = code_d;
        else if (state_d == S_RESUME)
            data_d = (req_q == RQ_PED_NS) ? CODE_EW_GREEN : CODE_NS_GREEN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            deb_cnt_q  <= '0;
            pend_q     <= '0;
            state_q    <= S_IDLE;
            req_q      <= RQ_EMERG;
            code_q     <= CODE_ALL_RED;
            hold_cnt_q <= '0;
            ld_q       <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= CODE_ALL_RED;
            ns_ack_q   <= 1'b0;
            ew_ack_q   <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            pend_q     <= pend_d;
            state_q    <= state_d;
            req_q      <= req_d;
            code_q     <= code_d;
            hold_cnt_q <= hold_cnt_d;
            ld_q       <= ld_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            ns_ack_q   <= ns_ack_d;
            ew_ack_q   <= ew_ack_d;
        end
    end

    assign ld_o         = ld_q;
    assign en_o         = en_q;
    assign busy_o       = busy_q;
    assign data_o       = data_q;
    assign ped_ns_ack_o = ns_ack_q;
    assign ped_ew_ack_o = ew_ack_q;

endmodule

// File: tb/tb_traffic_request_sequencer.sv
// Directed bench for traffic_request_sequencer with DEB_CYCLES=4,
// PED_CYCLES=10, EMERG_MIN=8. Inputs change 1 time unit after a rising edge,
// outputs are compared at that same point.
module tb_traffic_request_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni, auto_en_i, ped_ns_btn_i, ped_ew_btn_i, emerg_req_i, caution_req_i;
    logic       ld_o, en_o, busy_o, ped_ns_ack_o, ped_ew_ack_o;
    logic [3:0] data_o;

    int errors = 0;
    int checks = 0;
    int ld_rises = 0, ns_acks = 0, ew_acks = 0;
    logic ld_prev = 1'b0;
    int lat, n, r0, a0, a1;

    traffic_request_sequencer #(.DEB_CYCLES(4), .PED_CYCLES(10), .EMERG_MIN(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .auto_en_i(auto_en_i),
        .ped_ns_btn_i(ped_ns_btn_i), .ped_ew_btn_i(ped_ew_btn_i),
        .emerg_req_i(emerg_req_i), .caution_req_i(caution_req_i),
        .ld_o(ld_o), .data_o(data_o), .en_o(en_o), .busy_o(busy_o),
        .ped_ns_ack_o(ped_ns_ack_o), .ped_ew_ack_o(ped_ew_ack_o)
    );

    always #5 clk_i = ~clk_i;

    // Event counters and the ld/en exclusion, observed mid-cycle
    always @(negedge clk_i) begin
        if (ld_o && !ld_prev) ld_rises++;
        ld_prev = ld_o;
        if (ped_ns_ack_o) ns_acks++;
        if (ped_ew_ack_o) ew_acks++;
        checks++;
        assert (!(ld_o && en_o) === 1'b1) else begin
            errors++;
            $error("FAIL ld_en_exclusive: observed ld=%0b en=%0b expected not both", ld_o, en_o);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until ld is seen, returning the number of edges taken
    task automatic wait_ld(input int bound, output int l);
        l = 0;
        do begin
            tick;
            l++;
        end while (!ld_o && l < bound);
    endtask

    // Counts consecutive cycles showing ld=1, en=0 and the given hold code
    task automatic count_hold(input logic [3:0] code, input int bound, output int c);
        c = 0;
        while (ld_o && !en_o && data_o == code && c < bound) begin
            c++;
            tick;
        end
    endtask

    initial begin
        rst_ni = 1'b0; auto_en_i = 1'b1;
        ped_ns_btn_i = 1'b0; ped_ew_btn_i = 1'b0; emerg_req_i = 1'b0; caution_req_i = 1'b0;
        tick; tick;
        chk("rst_ld", ld_o, 0);
        chk("rst_data", data_o, 4'b0110);
        chk("rst_en", en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_acks", {ped_ns_ack_o, ped_ew_ack_o}, 0);
        rst_ni = 1'b1;
        tick;
        chk("post_rst_en", en_o, 1);
        chk("post_rst_ld", ld_o, 0);
        chk("post_rst_data", data_o, 4'b0110);
        chk("post_rst_busy", busy_o, 0);

        // East-west pedestrian, button held 10 cycles
        ped_ew_btn_i = 1'b1;
        repeat (7) tick;
        chk("ew_pre_load_ld", ld_o, 0);
        tick;
        chk("ew_load_ld", ld_o, 1);
        chk("ew_load_data", data_o, 4'b0110);
        chk("ew_load_en", en_o, 0);
        chk("ew_load_busy", busy_o, 1);
        tick;
        chk("ew_apply_ld", ld_o, 0);
        chk("ew_apply_en", en_o, 1);
        chk("ew_apply_data", data_o, 4'b0110);
        tick;
        ped_ew_btn_i = 1'b0;
        count_hold(4'b0110, 20, n);
        chk("ew_hold_len", n, 10);
        chk("ew_resume_ld", ld_o, 1);
        chk("ew_resume_data", data_o, 4'b0000);
        chk("ew_resume_ack_ew", ped_ew_ack_o, 1);
        chk("ew_resume_ack_ns", ped_ns_ack_o, 0);
        tick;
        chk("ew_idle_ld", ld_o, 0);
        chk("ew_idle_data", data_o, 4'b0000);
        chk("ew_idle_ack", ped_ew_ack_o, 0);
        chk("ew_idle_busy", busy_o, 0);
        chk("ew_idle_en", en_o, 1);

        // 3-cycle glitch is filtered, 4-cycle press is served
        r0 = ld_rises;
        ped_ns_btn_i = 1'b1;
        repeat (3) tick;
        ped_ns_btn_i = 1'b0;
        repeat (15) tick;
        chk("glitch_no_ld", ld_rises, r0);
        chk("glitch_busy", busy_o, 0);
        ped_ns_btn_i = 1'b1;
        repeat (4) tick;
        ped_ns_btn_i = 1'b0;
        wait_ld(20, lat);
        chk("ns_latency", lat, 4);
        chk("ns_load_data", data_o, 4'b0110);
        tick;
        chk("ns_apply_en", en_o, 1);
        tick;
        count_hold(4'b0110, 20, n);
        chk("ns_hold_len", n, 10);
        chk("ns_resume_data", data_o, 4'b0010);
        chk("ns_resume_ack", ped_ns_ack_o, 1);
        tick;

        // Emergency preempts a north-south hold
        a0 = ns_acks;
        ped_ns_btn_i = 1'b1;
        repeat (4) tick;
        ped_ns_btn_i = 1'b0;
        wait_ld(20, lat);
        chk("pre_ns_latency", lat, 4);
        tick; tick; tick;
        emerg_req_i = 1'b1;
        repeat (7) tick;
        chk("preempt_load_ld", ld_o, 1);
        chk("preempt_load_data", data_o, 4'b0110);
        tick;
        chk("preempt_apply_en", en_o, 1);
        chk("preempt_apply_ld", ld_o, 0);
        tick; tick;
        emerg_req_i = 1'b0;
        count_hold(4'b0110, 30, n);
        chk("emerg_hold_len", n + 1, 8);
        chk("emerg_resume_ld", ld_o, 1);
        chk("emerg_resume_data", data_o, 4'b0000);
        chk("emerg_resume_no_ack", ped_ns_ack_o, 0);
        wait_ld(5, lat);
        chk("reserve_latency", lat, 2);
        chk("reserve_data", data_o, 4'b0110);
        tick;
        chk("reserve_apply_en", en_o, 1);
        tick;
        count_hold(4'b0110, 20, n);
        chk("reserve_hold_len", n, 10);
        chk("reserve_resume_data", data_o, 4'b0010);
        chk("reserve_ack", ped_ns_ack_o, 1);
        tick;
        chk("emerg_ns_ack_count", ns_acks - a0, 1);

        // Caution and east-west arrive together: caution first
        a1 = ew_acks;
        caution_req_i = 1'b1;
        ped_ew_btn_i = 1'b1;
        wait_ld(20, lat);
        chk("caut_latency", lat, 7);
        chk("caut_load_data", data_o, 4'b1000);
        tick;
        chk("caut_apply_en", en_o, 1);
        ped_ew_btn_i = 1'b0;
        repeat (3) tick;
        caution_req_i = 1'b0;
        count_hold(4'b1000, 20, n);
        chk("caut_hold_after_release", n, 7);
        chk("caut_resume_data", data_o, 4'b0000);
        chk("caut_resume_no_ack", {ped_ns_ack_o, ped_ew_ack_o}, 0);
        wait_ld(5, lat);
        chk("caut_ew_latency", lat, 2);
        chk("caut_ew_data", data_o, 4'b0110);
        tick;
        tick;
        count_hold(4'b0110, 20, n);
        chk("caut_ew_hold_len", n, 10);
        chk("caut_ew_resume_data", data_o, 4'b0000);
        chk("caut_ew_ack", ped_ew_ack_o, 1);
        tick;
        chk("caut_ew_ack_count", ew_acks - a1, 1);

        // auto_en=0 keeps requests pending; reset mid-hold drops them
        auto_en_i = 1'b0;
        tick;
        chk("noauto_en", en_o, 0);
        ped_ns_btn_i = 1'b1;
        ped_ew_btn_i = 1'b1;
        repeat (5) tick;
        ped_ns_btn_i = 1'b0;
        ped_ew_btn_i = 1'b0;
        repeat (10) tick;
        chk("noauto_ld", ld_o, 0);
        chk("noauto_busy", busy_o, 0);
        auto_en_i = 1'b1;
        wait_ld(5, lat);
        chk("auto_latency", lat, 1);
        tick; tick; tick;
        chk("midhold_busy", busy_o, 1);
        r0 = ld_rises;
        a0 = ns_acks + ew_acks;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_ld", ld_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_en", en_o, 0);
        chk("async_rst_data", data_o, 4'b0110);
        tick;
        rst_ni = 1'b1;
        repeat (25) tick;
        chk("after_rst_no_ld", ld_rises, r0);
        chk("after_rst_no_ack", ns_acks + ew_acks, a0);
        chk("after_rst_busy", busy_o, 0);
        chk("after_rst_en", en_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
